clock_monitor: RTL and testbench

//  Receive-side checker for generated clocks (e.g. clock_unit o_clock0/o_clock1).
//  - Samples one monitored clock in the i_clock domain and measures every period in i_clock cycles.
//  - Declares lock after LOCK_COUNT consecutive in-tolerance periods.
//  - Flags a sticky fault when a locked clock drifts or stops.
//  - Gates downstream logic that must not run on an unproven clock.

---
 rtl/clock_monitor_pkg.sv | 14 +
 rtl/clock_monitor_sync_edge_detect.sv | 29 ++
 rtl/clock_monitor.sv | 158 +++++++++++++++
 tb/tb_clock_monitor.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock monitor: FSM state encoding.
// Also the reference encoding for benches that check monitor state.
`timescale 1ns/1ps
package clock_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/clock_monitor_sync_edge_detect.sv
// Two-flop synchroniser plus delay flop; one-cycle pulse on a rising edge.
// Generic enough to reuse for any slow asynchronous level input.
`timescale 1ns/1ps
module clock_monitor_sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/clock_monitor.sv
// Measures the period of an asynchronous clock in i_clock cycles, declares
// lock after a run of in-tolerance periods and raises a sticky fault on loss.
`timescale 1ns/1ps
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int EXPECTED_PERIOD = 10,
    parameter int TOLERANCE       = 1,
    parameter int LOCK_COUNT      = 8,
    parameter int TIMEOUT         = 64,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_mon_clock,
    input  logic                 i_src_valid,
    input  logic                 i_clear_fault,
    output logic                 o_locked,
    output logic                 o_fault,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic                 o_period_valid
);

    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] TMO   = CNT_WIDTH'(TIMEOUT);
    localparam logic [GW-1:0]        LCK   = GW'(LOCK_COUNT);
    localparam logic [CNT_WIDTH:0]   EXP_X = (CNT_WIDTH+1)'(EXPECTED_PERIOD);
    localparam logic [CNT_WIDTH:0]   TOL_X = (CNT_WIDTH+1)'(TOLERANCE);

    state_t               state;
    state_t               state_n;
    logic                 rise;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] period_n;
    logic [CNT_WIDTH:0]   meas_x;
    logic                 armed;
    logic                 armed_n;
    logic [GW-1:0]        gcnt;
    logic [GW-1:0]        gcnt_n;
    logic                 fault_set;
    logic                 fault_n;
    logic                 pv_n;
    logic                 good;
    logic                 tmo;
    logic                 meas;

    clock_monitor_sync_edge_detect u_sync (
        .clock (i_clock),
        .reset (i_reset),
        .din   (i_mon_clock),
        .rise  (rise)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_WIDTH'(1);
        end else if (cnt != TMO) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Widened compare: low bound never underflows when TOLERANCE > EXPECTED.
    assign meas_x = {1'b0, cnt};
    assign good   = ((meas_x + TOL_X) >= EXP_X) && (meas_x <= (EXP_X + TOL_X));
    assign tmo    = (cnt == TMO) && !rise;
    assign meas   = rise && armed;

    always_comb begin
        state_n   = state;
        armed_n   = armed;
        gcnt_n    = gcnt;
        fault_set = 1'b0;
        pv_n      = 1'b0;
        period_n  = o_period;

        if (meas) begin
            period_n = cnt;
            pv_n     = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                armed_n  = 1'b0;
                gcnt_n   = '0;
                pv_n     = 1'b0;
                period_n = o_period;
                state_n  = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (rise) begin
                    if (!armed) begin
                        armed_n = 1'b1;
                    end else if (good) begin
                        if (gcnt + 1'b1 == LCK) begin
                            gcnt_n  = '0;
                            state_n = ST_LOCKED;
                        end else begin
                            gcnt_n = gcnt + 1'b1;
                        end
                    end else begin
                        gcnt_n = '0;
                    end
                end else if (tmo) begin
                    armed_n = 1'b0;
                    gcnt_n  = '0;
                end
            end
            ST_LOCKED: begin
                if ((rise && !good) || tmo) begin
                    fault_set = 1'b1;
                    armed_n   = 1'b0;
                    gcnt_n    = '0;
                    state_n   = ST_ACQUIRE;
                end
            end
            default: begin
                armed_n = 1'b0;
                gcnt_n  = '0;
                state_n = ST_IDLE;
            end
        endcase

        // Losing the source beats every other event in the same cycle.
        if (!i_src_valid) begin
            state_n   = ST_IDLE;
            armed_n   = 1'b0;
            gcnt_n    = '0;
            pv_n      = 1'b0;
            fault_set = 1'b0;
            period_n  = o_period;
        end

        fault_n = fault_set | (o_fault & ~i_clear_fault);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state          <= ST_IDLE;
            armed          <= 1'b0;
            gcnt           <= '0;
            o_fault        <= 1'b0;
            o_period       <= '0;
            o_period_valid <= 1'b0;
        end else begin
            state          <= state_n;
            armed          <= armed_n;
            gcnt           <= gcnt_n;
            o_fault        <= fault_n;
            o_period       <= period_n;
            o_period_valid <= pv_n;
        end
    end

    assign o_locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_clock_monitor.sv
// Scoreboard bench for clock_monitor: expected periods are queued as the
// monitored clock is driven and popped on every o_period_valid pulse.
`timescale 1ns/1ps
module tb_clock_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mon   = 1'b0;
    logic        src   = 1'b0;
    logic        clr   = 1'b0;
    logic        locked;
    logic        fault;
    logic [15:0] period;
    logic        pv;

    int n_tests = 0;
    int n_fail  = 0;
    int q[$];
    bit armed_m = 1'b0;
    int last_p  = 0;
    int pv_cnt  = 0;

    clock_monitor dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_mon_clock    (mon),
        .i_src_valid    (src),
        .i_clear_fault  (clr),
        .o_locked       (locked),
        .o_fault        (fault),
        .o_period       (period),
        .o_period_valid (pv)
    );

    always #4 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (pv) begin
            pv_cnt++;
            if (q.size() == 0) check("pv_unexpected", int'(pv), 0);
            else check("period", int'(period), q.pop_front());
        end
    end

    task automatic align();
        @(posedge clock);
        #3;
    endtask

    // One monitored period of p cycles starting with a rise now.
    task automatic mon_period(input int p);
        if (armed_m) q.push_back(last_p);
        armed_m = 1'b1;
        last_p  = p;
        mon = 1'b1;
        #(4 * p);
        mon = 1'b0;
        #(4 * p);
    endtask

    // Final rise, then hold low until the fault appears; n = posedges to fault.
    task automatic stop_after(input int p, input bit with_clr, output int n);
        if (armed_m) q.push_back(last_p);
        mon = 1'b1;
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clock);
            #1;
            if (i == p / 2) mon = 1'b0;
            if (with_clr) clr = (i == 66);
            n = i;
            if (fault) break;
        end
        clr = 1'b0;
        armed_m = 1'b0;
    endtask

    task automatic clear_pulse();
        @(posedge clock);
        #1 clr = 1'b1;
        @(posedge clock);
        #1 clr = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: sim time exceeded, got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        int t2[13] = '{9, 11, 9, 12, 11, 9, 11, 9, 11, 9, 11, 9, 10};

        #10;
        check("rst_locked", int'(locked), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_period", int'(period), 0);
        check("rst_pv", int'(pv), 0);
        #10 reset = 1'b0;
        #80 src = 1'b1;

        // Nominal 80 ns clock: lock on the 9th rise.
        align();
        for (int i = 0; i < 8; i++) mon_period(10);
        check("t1_not_yet", int'(locked), 0);
        mon_period(10);
        check("t1_locked", int'(locked), 1);
        check("t1_fault", int'(fault), 0);

        // One 13-cycle period while locked.
        mon_period(13);
        mon_period(10);
        armed_m = 1'b0;
        check("t3_fault", int'(fault), 1);
        check("t3_unlocked", int'(locked), 0);
        for (int i = 0; i < 8; i++) mon_period(10);
        check("t3_relock_pending", int'(locked), 0);
        mon_period(10);
        check("t3_relocked", int'(locked), 1);
        check("t3_fault_sticky", int'(fault), 1);

        // Source drop for one cycle.
        @(posedge clock);
        #1 src = 1'b0;
        @(posedge clock);
        #1 src = 1'b1;
        check("t5_unlocked", int'(locked), 0);
        check("t5_fault_held", int'(fault), 1);
        armed_m = 1'b0;
        clear_pulse();
        check("t5_cleared", int'(fault), 0);

        // Alternating 9/11 with a 12-cycle period inside acquisition.
        align();
        for (int i = 0; i < 12; i++) mon_period(t2[i]);
        check("t2_not_yet", int'(locked), 0);
        check("t2_no_fault", int'(fault), 0);
        mon_period(t2[12]);
        check("t2_locked", int'(locked), 1);

        // Stopped clock while locked.
        stop_after(10, 1'b0, n);
        check("t4_tmo_cycles", n, 67);
        check("t4_fault", int'(fault), 1);
        check("t4_unlocked", int'(locked), 0);
        clear_pulse();
        check("t4_cleared", int'(fault), 0);

        // Relock, then time out with a clear in the same cycle.
        align();
        for (int i = 0; i < 9; i++) mon_period(10);
        check("t4b_locked", int'(locked), 1);
        stop_after(10, 1'b1, n);
        check("t4b_tmo_cycles", n, 67);
        check("t4b_fault_wins", int'(fault), 1);
        clear_pulse();
        check("t4b_cleared", int'(fault), 0);

        // Asynchronous reset mid-period.
        align();
        for (int i = 0; i < 3; i++) mon_period(10);
        #20 reset = 1'b1;
        #1;
        check("t6_period", int'(period), 0);
        check("t6_locked", int'(locked), 0);
        check("t6_fault", int'(fault), 0);
        check("t6_pv", int'(pv), 0);
        #20 reset = 1'b0;
        armed_m = 1'b0;
        q.delete();
        align();
        p0 = pv_cnt;
        mon_period(10);
        check("t6_first_edge_no_pv", pv_cnt, p0);
        mon_period(10);
        check("t6_second_edge_pv", pv_cnt, p0 + 1);

        repeat (5) @(posedge clock);
        #1;
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
